fp_add_pipe: RTL

Pipelined, parametrised IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on both sides. It succeeds the team's single-cycle half-precision adder and generalises exponent and mantissa widths. It adds a subtract mode, full leading-zero normalisation, round-to-nearest-even with guard/round/sticky, special-value handling and exception flags. It sits between operand-issue logic and the result writeback in the datapath, accepting one operation per cycle at full throughput.

---
 rtl/fp_add_pipe_if.sv | 28 ++
 rtl/fp_add_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe_if.sv
// Operand/result handshake bundle for fp_add_pipe.
// master: operand source + result consumer; slave: the adder itself.
interface fp_add_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   localparam int FP_W = 1 + EXP_W + MAN_W;

   logic            in_valid;
   logic            in_ready;
   logic [FP_W-1:0] a;
   logic [FP_W-1:0] b;
   logic            sub;
   logic            out_valid;
   logic            out_ready;
   logic [FP_W-1:0] res;
   logic [3:0]      flags;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, res, flags
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, res, flags
   );
endinterface

// File: rtl/fp_add_pipe.sv
// Pipelined floating-point adder/subtractor, round-to-nearest-even.
// Operands are captured into an input register, then pass S1 (unpack,
// compare, align), S2 (add/sub) and S3 (normalise, round, pack) into the
// output register: accepted at edge k, result visible after edge k+3.
// One global advance signal moves every stage; bubbles carry valid=0.
// flags = {invalid, overflow, underflow, inexact}.
module fp_add_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input logic          clk,
   input logic          rst_n,
   fp_add_pipe_if.slave fp_io
);
   localparam int FP_W  = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 4;              // {hidden, frac, G, R, S}
   localparam int SUM_W = MAN_W + 5;              // SIG_W plus carry
   localparam int LZW   = $clog2(SIG_W) + 1;
   localparam int XW    = EXP_W + LZW + 2;        // working exponent, two's complement

   localparam logic [EXP_W-1:0] EXP_ONES  = '1;
   localparam logic [EXP_W-1:0] EXP_ZERO  = '0;
   localparam logic [MAN_W-1:0] FRAC_ZERO = '0;
   localparam logic [FP_W-1:0]  QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [XW-1:0]    XONE      = {{(XW-1){1'b0}}, 1'b1};
   localparam logic [XW-1:0]    EXP_MAX   = {{(XW-EXP_W){1'b0}}, EXP_ONES};

   // Leading-zero count of a significand (returns SIG_W for all-zero input).
   function automatic logic [LZW-1:0] lzc_f(input logic [SIG_W-1:0] v);
      logic [LZW-1:0] n;
      logic           found;
      n     = '0;
      found = 1'b0;
      for (int i = SIG_W - 1; i >= 0; i--) begin
         found = found | v[i];
         n     = n + {{(LZW-1){1'b0}}, ~found};
      end
      return n;
   endfunction

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic            advance_s;
   logic            v0_q, v1_q, v2_q, out_valid_q;
   logic [FP_W-1:0] res_q, res_d;
   logic [3:0]      flags_q, flags_d;

   assign advance_s       = fp_io.out_ready | ~out_valid_q;
   assign fp_io.in_ready  = advance_s;
   assign fp_io.out_valid = out_valid_q;
   assign fp_io.res       = res_q;
   assign fp_io.flags     = flags_q;

   // ------------------------------------------------------------------
   // Input capture
   // ------------------------------------------------------------------
   logic [FP_W-1:0] a0_q, b0_q;
   logic            sub0_q;

   // ------------------------------------------------------------------
   // S1: unpack, flush zero-exponent operands, compare, specials, align
   // ------------------------------------------------------------------
   logic             sa_s, sb_s;
   logic [EXP_W-1:0] ea_s, eb_s;
   logic [MAN_W-1:0] fa_s, fb_s, fa_f_s, fb_f_s;
   logic             a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
   logic             a_ge_s;
   logic [SIG_W-1:0] sig_a_s, sig_b_s, sig_sm_s;
   logic [EXP_W-1:0] exp_sm_s, diff_s;

   logic             spec1_d, spec1_q;
   logic [FP_W-1:0]  spec_res1_d, spec_res1_q;
   logic             spec_inv1_d, spec_inv1_q;
   logic             sign1_d, sign1_q;
   logic             effsub1_d, effsub1_q;
   logic [EXP_W-1:0] exp1_d, exp1_q;
   logic [SIG_W-1:0] sigl1_d, sigl1_q;
   logic [SIG_W-1:0] sigs1_d, sigs1_q;

   assign sa_s     = a0_q[FP_W-1];
   assign sb_s     = b0_q[FP_W-1] ^ sub0_q;
   assign ea_s     = a0_q[FP_W-2:MAN_W];
   assign eb_s     = b0_q[FP_W-2:MAN_W];
   assign fa_s     = a0_q[MAN_W-1:0];
   assign fb_s     = b0_q[MAN_W-1:0];
   assign a_zero_s = (ea_s == EXP_ZERO);
   assign b_zero_s = (eb_s == EXP_ZERO);
   assign fa_f_s   = a_zero_s ? FRAC_ZERO : fa_s;
   assign fb_f_s   = b_zero_s ? FRAC_ZERO : fb_s;
   assign a_inf_s  = (ea_s == EXP_ONES) && (fa_s == FRAC_ZERO);
   assign b_inf_s  = (eb_s == EXP_ONES) && (fb_s == FRAC_ZERO);
   assign a_nan_s  = (ea_s == EXP_ONES) && (fa_s != FRAC_ZERO);
   assign b_nan_s  = (eb_s == EXP_ONES) && (fb_s != FRAC_ZERO);
   assign a_ge_s   = {ea_s, fa_f_s} >= {eb_s, fb_f_s};
   assign sig_a_s  = {~a_zero_s, fa_f_s, 3'b000};
   assign sig_b_s  = {~b_zero_s, fb_f_s, 3'b000};

   assign spec1_d   = a_inf_s | b_inf_s | a_nan_s | b_nan_s;
   assign sign1_d   = a_ge_s ? sa_s : sb_s;
   assign effsub1_d = sa_s ^ sb_s;
   assign exp1_d    = a_ge_s ? ea_s : eb_s;
   assign exp_sm_s  = a_ge_s ? eb_s : ea_s;
   assign sigl1_d   = a_ge_s ? sig_a_s : sig_b_s;
   assign sig_sm_s  = a_ge_s ? sig_b_s : sig_a_s;
   assign diff_s    = exp1_d - exp_sm_s;

   // Special-operand result: NaN propagation, Inf arithmetic, Inf-Inf invalid.
   always_comb begin
      spec_res1_d = '0;
      spec_inv1_d = 1'b0;
      if (a_nan_s || b_nan_s) begin
         spec_res1_d = QNAN;
      end else if (a_inf_s && b_inf_s) begin
         if (sa_s == sb_s) begin
            spec_res1_d = {sa_s, EXP_ONES, FRAC_ZERO};
         end else begin
            spec_res1_d = QNAN;
            spec_inv1_d = 1'b1;
         end
      end else if (a_inf_s) begin
         spec_res1_d = {sa_s, EXP_ONES, FRAC_ZERO};
      end else if (b_inf_s) begin
         spec_res1_d = {sb_s, EXP_ONES, FRAC_ZERO};
      end else begin
         spec_res1_d = '0;
      end
   end

   // Right-align the smaller significand, folding shifted-out bits into sticky.
   always_comb begin
      sigs1_d = '0;
      if (32'(diff_s) >= 32'(MAN_W + 3)) begin
         sigs1_d = {{(SIG_W-1){1'b0}}, |sig_sm_s};
      end else begin
         sigs1_d = (sig_sm_s >> diff_s)
                 | {{(SIG_W-1){1'b0}}, |(sig_sm_s & ~({SIG_W{1'b1}} << diff_s))};
      end
   end

   // ------------------------------------------------------------------
   // S2: magnitude add / subtract (larger minus smaller, never negative)
   // ------------------------------------------------------------------
   logic [SUM_W-1:0] sum2_d, sum2_q;
   logic             spec2_q, spec_inv2_q, sign2_q, effsub2_q;
   logic [FP_W-1:0]  spec_res2_q;
   logic [EXP_W-1:0] exp2_q;

   // Significand add or subtract selected by the effective operation.
   always_comb begin
      sum2_d = '0;
      if (effsub1_q) begin
         sum2_d = {1'b0, sigl1_q} - {1'b0, sigs1_q};
      end else begin
         sum2_d = {1'b0, sigl1_q} + {1'b0, sigs1_q};
      end
   end

   // ------------------------------------------------------------------
   // S3: normalise, round to nearest even, range check, pack
   // ------------------------------------------------------------------
   logic [LZW-1:0]   lz_s;
   logic [XW-1:0]    exp_x_s, exp_n_s, exp_f_s;
   logic [SUM_W-1:0] norm_s;
   logic [MAN_W:0]   mant_s;
   logic [MAN_W+1:0] mant_r_s;
   logic [MAN_W-1:0] frac_s;
   logic             g_s, r_s, st_s, rup_s, inexact_s;

   assign lz_s    = lzc_f(sum2_q[SIG_W-1:0]);
   assign exp_x_s = {{(XW-EXP_W){1'b0}}, exp2_q};

   // Normalisation shift and rounding of the raw sum.
   always_comb begin
      norm_s = '0;
      exp_n_s = '0;
      if (sum2_q[SUM_W-1]) begin
         norm_s  = {1'b0, sum2_q[SUM_W-1:2], sum2_q[1] | sum2_q[0]};
         exp_n_s = exp_x_s + XONE;
      end else begin
         norm_s  = sum2_q << lz_s;
         exp_n_s = exp_x_s - {{(XW-LZW){1'b0}}, lz_s};
      end
      mant_s    = norm_s[SUM_W-2:3];
      g_s       = norm_s[2];
      r_s       = norm_s[1];
      st_s      = norm_s[0];
      inexact_s = g_s | r_s | st_s;
      rup_s     = g_s & (r_s | st_s | norm_s[3]);
      mant_r_s  = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, rup_s};
      if (mant_r_s[MAN_W+1]) begin
         frac_s  = mant_r_s[MAN_W:1];
         exp_f_s = exp_n_s + XONE;
      end else begin
         frac_s  = mant_r_s[MAN_W-1:0];
         exp_f_s = exp_n_s;
      end
   end

   // Final result select: specials, exact zero, overflow, underflow, normal.
   always_comb begin
      res_d   = '0;
      flags_d = 4'b0000;
      if (spec2_q) begin
         res_d   = spec_res2_q;
         flags_d = {spec_inv2_q, 3'b000};
      end else if (sum2_q == '0) begin
         res_d   = {sign2_q & ~effsub2_q, EXP_ZERO, FRAC_ZERO};
         flags_d = 4'b0000;
      end else if (!exp_f_s[XW-1] && (exp_f_s >= EXP_MAX)) begin
         res_d   = {sign2_q, EXP_ONES, FRAC_ZERO};
         flags_d = 4'b0101;
      end else if (exp_f_s[XW-1] || (exp_f_s == '0)) begin
         res_d   = {sign2_q, EXP_ZERO, FRAC_ZERO};
         flags_d = 4'b0011;
      end else begin
         res_d   = {sign2_q, exp_f_s[EXP_W-1:0], frac_s};
         flags_d = {3'b000, inexact_s};
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------

   // Valid chain and output register: reset clears, advance shifts, stall holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         flags_q     <= 4'b0000;
      end else if (advance_s) begin
         v0_q        <= fp_io.in_valid;
         v1_q        <= v0_q;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         if (v2_q) begin
            res_q   <= res_d;
            flags_q <= flags_d;
         end
      end
   end

   // Datapath stage registers: no reset, qualified by the valid chain.
   always_ff @(posedge clk) begin
      if (advance_s) begin
         if (fp_io.in_valid) begin
            a0_q   <= fp_io.a;
            b0_q   <= fp_io.b;
            sub0_q <= fp_io.sub;
         end
         spec1_q     <= spec1_d;
         spec_res1_q <= spec_res1_d;
         spec_inv1_q <= spec_inv1_d;
         sign1_q     <= sign1_d;
         effsub1_q   <= effsub1_d;
         exp1_q      <= exp1_d;
         sigl1_q     <= sigl1_d;
         sigs1_q     <= sigs1_d;
         spec2_q     <= spec1_q;
         spec_res2_q <= spec_res1_q;
         spec_inv2_q <= spec_inv1_q;
         sign2_q     <= sign1_q;
         effsub2_q   <= effsub1_q;
         exp2_q      <= exp1_q;
         sum2_q      <= sum2_d;
      end
   end
endmodule
